// File: rtl/hv_desat_flt_ctrl.sv
// DESAT protection sequencer: blanks and deglitches the comparator, runs a two-level/soft turn-off,
// then latches the fault until cleared. All outputs are registered decodes of the next state.
module hv_desat_flt_ctrl #(
   parameter int BLANK_UNIT = 16,
   parameter int DGL_UNIT   = 4,
   parameter int TLT_UNIT   = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pwm_on,
   input  logic       desat_cmp,
   input  logic       desat_dig_en,
   input  logic [2:0] desat_blanking,
   input  logic [2:0] desat_deglitch_sel,
   input  logic [1:0] t_tltoff,
   input  logic       tlt_sof_sel,
   input  logic       flt_clr,
   output logic       gate_on,
   output logic       desat_det_en,
   output logic       tlt_en,
   output logic       sof_en,
   output logic       desat_flt,
   output logic [7:0] flt_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_BLANK, S_MON, S_DGL, S_TLT, S_FLT} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [2:0] snap_dgl;
   logic       snap_en;
   logic       sof_sel, sof_sel_nxt;
   logic       fault_hit, flt_exit;
   logic       gate_nxt, det_nxt, tlt_nxt, sof_nxt, flt_nxt;
   logic [7:0] blank_load, dgl_load, tlt_load;

   // Blanking code is consumed straight into the counter on the IDLE exit edge, so the counter
   // itself holds the snapshot. The deglitch window counts the MON sample that opened it,
   // hence DGL itself lasts one cycle less than the full window.
   assign blank_load = 8'(BLANK_UNIT * (int'(desat_blanking) + 1) - 1);
   assign dgl_load   = 8'(DGL_UNIT * (int'(snap_dgl) + 1) - 2);
   assign tlt_load   = 8'(TLT_UNIT * (int'(t_tltoff) + 1) - 1);

   assign fault_hit = (state == S_DGL) && (state_nxt == S_TLT);
   assign flt_exit  = (state == S_FLT) && (state_nxt == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= 8'd0;
         snap_dgl     <= 3'd0;
         snap_en      <= 1'b0;
         sof_sel      <= 1'b0;
         gate_on      <= 1'b0;
         desat_det_en <= 1'b0;
         tlt_en       <= 1'b0;
         sof_en       <= 1'b0;
         desat_flt    <= 1'b0;
         flt_cnt      <= 8'd0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         sof_sel      <= sof_sel_nxt;
         gate_on      <= gate_nxt;
         desat_det_en <= det_nxt;
         tlt_en       <= tlt_nxt;
         sof_en       <= sof_nxt;
         desat_flt    <= flt_nxt;
         if (state == S_IDLE && pwm_on) begin
            snap_dgl <= desat_deglitch_sel;
            snap_en  <= desat_dig_en;
         end
         if (fault_hit && flt_cnt != 8'hff)
            flt_cnt <= flt_cnt + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
      case (state)
         S_IDLE: begin
            cnt_nxt = 8'd0;
            if (pwm_on) begin
               state_nxt = S_BLANK;
               cnt_nxt   = blank_load;
            end
         end
         S_BLANK: begin
            if (!pwm_on)              state_nxt = S_IDLE;
            else if (cnt == 8'd0)     state_nxt = S_MON;
         end
         S_MON: begin
            if (!pwm_on) begin
               state_nxt = S_IDLE;
            end else if (desat_cmp && snap_en) begin
               state_nxt = S_DGL;
               cnt_nxt   = dgl_load;
            end
         end
         S_DGL: begin
            if (!pwm_on) begin
               state_nxt = S_IDLE;
            end else if (!desat_cmp) begin
               state_nxt = S_MON;
            end else if (cnt == 8'd0) begin
               state_nxt = S_TLT;
               cnt_nxt   = tlt_load;
            end
         end
         S_TLT: begin
            if (cnt == 8'd0) state_nxt = S_FLT;
         end
         S_FLT: begin
            if (flt_clr && !pwm_on) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      sof_sel_nxt = fault_hit ? tlt_sof_sel : sof_sel;
      gate_nxt    = (state_nxt == S_BLANK) || (state_nxt == S_MON) || (state_nxt == S_DGL);
      det_nxt     = ((state_nxt == S_MON) && snap_en) || (state_nxt == S_DGL);
      tlt_nxt     = (state_nxt == S_TLT) && !sof_sel_nxt;
      sof_nxt     = (state_nxt == S_TLT) && sof_sel_nxt;
      flt_nxt     = desat_flt;
      if (fault_hit) flt_nxt = 1'b1;
      else if (flt_exit) flt_nxt = 1'b0;
   end

endmodule

// File: tb/tb_hv_desat_flt_ctrl.sv
// Directed bench for hv_desat_flt_ctrl: per-scenario tasks with hand-derived cycle expectations.
module tb_hv_desat_flt_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pwm_on, desat_cmp, desat_dig_en, tlt_sof_sel, flt_clr;
   logic [2:0] desat_blanking, desat_deglitch_sel;
   logic [1:0] t_tltoff;
   logic       gate_on, desat_det_en, tlt_en, sof_en, desat_flt;
   logic [7:0] flt_cnt;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   hv_desat_flt_ctrl dut (
      .clk(clk), .rst_n(rst_n), .pwm_on(pwm_on), .desat_cmp(desat_cmp),
      .desat_dig_en(desat_dig_en), .desat_blanking(desat_blanking),
      .desat_deglitch_sel(desat_deglitch_sel), .t_tltoff(t_tltoff),
      .tlt_sof_sel(tlt_sof_sel), .flt_clr(flt_clr), .gate_on(gate_on),
      .desat_det_en(desat_det_en), .tlt_en(tlt_en), .sof_en(sof_en),
      .desat_flt(desat_flt), .flt_cnt(flt_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fault();
      pwm_on = 1'b0; desat_cmp = 1'b0;
      tick();
      flt_clr = 1'b1;
      tick();
      flt_clr = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      total++; if (gate_on !== 1'b0)      begin bad++; $display("FAIL rst_gate got=%b exp=0", gate_on); end
      total++; if (desat_det_en !== 1'b0) begin bad++; $display("FAIL rst_det got=%b exp=0", desat_det_en); end
      total++; if (tlt_en !== 1'b0)       begin bad++; $display("FAIL rst_tlt got=%b exp=0", tlt_en); end
      total++; if (sof_en !== 1'b0)       begin bad++; $display("FAIL rst_sof got=%b exp=0", sof_en); end
      total++; if (desat_flt !== 1'b0)    begin bad++; $display("FAIL rst_flt got=%b exp=0", desat_flt); end
      total++; if (flt_cnt !== 8'd0)      begin bad++; $display("FAIL rst_cnt got=%0d exp=0", flt_cnt); end
   endtask

   // 200-cycle pulse, no desat: gate high after edges 1..200, detector from edge 17
   task automatic test_plain_pulse();
      desat_blanking = 3'd0; desat_dig_en = 1'b1; desat_cmp = 1'b0;
      pwm_on = 1'b1;
      for (int i = 1; i <= 216; i++) begin
         tick();
         if (i == 200) pwm_on = 1'b0;
         total++; if (gate_on !== (i <= 200))
            begin bad++; $display("FAIL plain_gate edge=%0d got=%b exp=%b", i, gate_on, (i <= 200)); end
         total++; if (desat_det_en !== (i >= 17 && i <= 200))
            begin bad++; $display("FAIL plain_det edge=%0d got=%b exp=%b", i, desat_det_en, (i >= 17 && i <= 200)); end
         total++; if (desat_flt !== 1'b0)
            begin bad++; $display("FAIL plain_flt edge=%0d got=%b exp=0", i, desat_flt); end
      end
   endtask

   // blank 48, deglitch 8 (incl. MON sample): fault at edge 57, then hold of hold_n cycles
   task automatic test_turn_off(input logic sel, input logic [1:0] code, input int hold_n);
      desat_blanking = 3'd2; desat_deglitch_sel = 3'd1; desat_dig_en = 1'b1;
      t_tltoff = code; tlt_sof_sel = sel; desat_cmp = 1'b1;
      pwm_on = 1'b1;
      for (int i = 1; i <= 56 + hold_n + 10; i++) begin
         tick();
         total++; if (gate_on !== (i <= 56))
            begin bad++; $display("FAIL to_gate sel=%b edge=%0d got=%b exp=%b", sel, i, gate_on, (i <= 56)); end
         total++; if (desat_det_en !== (i >= 49 && i <= 56))
            begin bad++; $display("FAIL to_det sel=%b edge=%0d got=%b exp=%b", sel, i, desat_det_en, (i >= 49 && i <= 56)); end
         total++; if (tlt_en !== (!sel && i >= 57 && i <= 56 + hold_n))
            begin bad++; $display("FAIL to_tlt sel=%b edge=%0d got=%b", sel, i, tlt_en); end
         total++; if (sof_en !== (sel && i >= 57 && i <= 56 + hold_n))
            begin bad++; $display("FAIL to_sof sel=%b edge=%0d got=%b", sel, i, sof_en); end
         total++; if (desat_flt !== (i >= 57))
            begin bad++; $display("FAIL to_flt sel=%b edge=%0d got=%b exp=%b", sel, i, desat_flt, (i >= 57)); end
      end
      exp_cnt++;
      total++; if (flt_cnt !== 8'(exp_cnt))
         begin bad++; $display("FAIL to_cnt got=%0d exp=%0d", flt_cnt, exp_cnt); end
      clear_fault();
   endtask

   // MON at 17; highs sampled at edges 18..24 (7), low at 25, highs from 26 -> fault at 33
   task automatic test_glitch();
      desat_blanking = 3'd0; desat_deglitch_sel = 3'd1; t_tltoff = 2'd0; tlt_sof_sel = 1'b0;
      desat_cmp = 1'b0;
      pwm_on = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         desat_cmp = ((i + 1 >= 18 && i + 1 <= 24) || i + 1 >= 26);
         total++; if (desat_flt !== (i >= 33))
            begin bad++; $display("FAIL glitch_flt edge=%0d got=%b exp=%b", i, desat_flt, (i >= 33)); end
         total++; if (gate_on !== (i <= 32))
            begin bad++; $display("FAIL glitch_gate edge=%0d got=%b exp=%b", i, gate_on, (i <= 32)); end
      end
      exp_cnt++;
      total++; if (flt_cnt !== 8'(exp_cnt))
         begin bad++; $display("FAIL glitch_cnt got=%0d exp=%0d", flt_cnt, exp_cnt); end
   endtask

   // entered with the fault latched in FLT and pwm_on still high
   task automatic test_flt_clear();
      flt_clr = 1'b1;
      tick();
      flt_clr = 1'b0;
      tick();
      total++; if (desat_flt !== 1'b1)
         begin bad++; $display("FAIL clr_held_flt got=%b exp=1", desat_flt); end
      total++; if (gate_on !== 1'b0)
         begin bad++; $display("FAIL clr_held_gate got=%b exp=0", gate_on); end
      pwm_on = 1'b0; desat_cmp = 1'b0;
      tick();
      total++; if (desat_flt !== 1'b1)
         begin bad++; $display("FAIL clr_noclr_flt got=%b exp=1", desat_flt); end
      flt_clr = 1'b1;
      tick();
      flt_clr = 1'b0;
      total++; if (desat_flt !== 1'b0)
         begin bad++; $display("FAIL clr_flt got=%b exp=0", desat_flt); end
      pwm_on = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         total++; if (gate_on !== 1'b1)
            begin bad++; $display("FAIL clr_newgate edge=%0d got=%b exp=1", i, gate_on); end
         total++; if (desat_det_en !== (i >= 17))
            begin bad++; $display("FAIL clr_newdet edge=%0d got=%b exp=%b", i, desat_det_en, (i >= 17)); end
      end
      pwm_on = 1'b0;
      tick(); tick();
      total++; if (flt_cnt !== 8'(exp_cnt))
         begin bad++; $display("FAIL clr_cnt got=%0d exp=%0d", flt_cnt, exp_cnt); end
   endtask

   // pwm_on falls while deglitching (32-cycle window): back to IDLE, no fault
   task automatic test_pwm_priority();
      desat_blanking = 3'd0; desat_deglitch_sel = 3'd7; desat_cmp = 1'b1;
      pwm_on = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i == 25) pwm_on = 1'b0;
         total++; if (gate_on !== (i <= 25))
            begin bad++; $display("FAIL prio_gate edge=%0d got=%b exp=%b", i, gate_on, (i <= 25)); end
         total++; if (desat_det_en !== (i >= 17 && i <= 25))
            begin bad++; $display("FAIL prio_det edge=%0d got=%b exp=%b", i, desat_det_en, (i >= 17 && i <= 25)); end
      end
      total++; if (desat_flt !== 1'b0)
         begin bad++; $display("FAIL prio_flt got=%b exp=0", desat_flt); end
      total++; if (flt_cnt !== 8'(exp_cnt))
         begin bad++; $display("FAIL prio_cnt got=%0d exp=%0d", flt_cnt, exp_cnt); end
      desat_cmp = 1'b0;
   endtask

   // disabled at pulse start; enabling mid-pulse must not take effect
   task automatic test_disable();
      desat_blanking = 3'd0; desat_deglitch_sel = 3'd0; desat_dig_en = 1'b0; desat_cmp = 1'b1;
      pwm_on = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (i == 3) desat_dig_en = 1'b1;
         total++; if (gate_on !== 1'b1)
            begin bad++; $display("FAIL dis_gate edge=%0d got=%b exp=1", i, gate_on); end
         total++; if (desat_det_en !== 1'b0)
            begin bad++; $display("FAIL dis_det edge=%0d got=%b exp=0", i, desat_det_en); end
         total++; if (desat_flt !== 1'b0)
            begin bad++; $display("FAIL dis_flt edge=%0d got=%b exp=0", i, desat_flt); end
      end
      pwm_on = 1'b0; desat_cmp = 1'b0;
      tick(); tick();
      total++; if (gate_on !== 1'b0)
         begin bad++; $display("FAIL dis_gate_off got=%b exp=0", gate_on); end
   endtask

   task automatic test_saturation();
      desat_blanking = 3'd0; desat_deglitch_sel = 3'd0; desat_dig_en = 1'b1;
      t_tltoff = 2'd0; tlt_sof_sel = 1'b0;
      for (int n = 0; n < 256; n++) begin
         pwm_on = 1'b1; desat_cmp = 1'b1;
         for (int t = 0; t < 200 && !desat_flt; t++) tick();
         total++; if (desat_flt !== 1'b1)
            begin bad++; $display("FAIL sat_timeout n=%0d got=%b exp=1", n, desat_flt); end
         for (int t = 0; t < 40; t++) tick();
         if (exp_cnt < 255) exp_cnt++;
         total++; if (flt_cnt !== 8'(exp_cnt))
            begin bad++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, flt_cnt, exp_cnt); end
         clear_fault();
      end
      total++; if (flt_cnt !== 8'd255)
         begin bad++; $display("FAIL sat_final got=%0d exp=255", flt_cnt); end
   endtask

   // async reset in the middle of the turn-off hold
   task automatic test_reset_mid_tlt();
      pwm_on = 1'b1; desat_cmp = 1'b1;
      for (int t = 0; t < 200 && !tlt_en; t++) tick();
      total++; if (tlt_en !== 1'b1)
         begin bad++; $display("FAIL rtlt_timeout got=%b exp=1", tlt_en); end
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      test_reset();
      pwm_on = 1'b0; desat_cmp = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (gate_on !== 1'b0)
         begin bad++; $display("FAIL rtlt_idle got=%b exp=0", gate_on); end
   endtask

   initial begin
      rst_n = 1'b0; pwm_on = 1'b0; desat_cmp = 1'b0; desat_dig_en = 1'b0;
      desat_blanking = 3'd0; desat_deglitch_sel = 3'd0; t_tltoff = 2'd0;
      tlt_sof_sel = 1'b0; flt_clr = 1'b0;
      #23;
      test_reset();
      tick();
      rst_n = 1'b1;
      tick();
      test_plain_pulse();
      test_turn_off(1'b0, 2'd0, 24);
      test_turn_off(1'b1, 2'd3, 96);
      test_glitch();
      test_flt_clear();
      test_pwm_priority();
      test_disable();
      test_saturation();
      test_reset_mid_tlt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
